// File: rtl/sysid_check_if.sv
// Avalon-MM status slave bus between the Nios II CPU and sysid_check.
// Read data is combinational from the address, so there are no wait states.
interface sysid_check_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/sysid_check.sv
// Boot-time system ID check: reads sysid words 0 and 1, compares them against build constants,
// gates the OLED enable on the result and exposes status over an Avalon-MM slave.
module sysid_check #(
    parameter logic [31:0] EXPECTED_ID   = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS   = 32'h5552_AD02,
    parameter bit          CHECK_TS      = 1'b1,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    sysid_check_if.slave bus,
    output logic        oled_enable,
    output logic        id_fail
);

    typedef enum logic [2:0] {
        StSettle,
        StRdId,
        StRdTs,
        StCmp,
        StDone
    } state_e;

    localparam bit          SkipSettle = (SETTLE_CYCLES == 0);
    localparam logic [15:0] SettleLast = SkipSettle ? 16'd0 : 16'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        addr_q, addr_d;
    logic [31:0] cap_id_q, cap_id_d;
    logic [31:0] cap_ts_q, cap_ts_d;
    logic        ok_q, ok_d;
    logic        fail_q, fail_d;
    logic        done_q, done_d;
    logic [7:0]  mism_q, mism_d;
    logic        oled_q, oled_d;
    logic        idf_q, idf_d;

    logic        wr_ctrl;
    logic        recheck;
    logic        clr_count;
    logic        pass;
    logic        unused_bits;

    assign wr_ctrl   = bus.avs_write && (bus.avs_address == 2'd0);
    assign recheck   = wr_ctrl && bus.avs_writedata[0];
    assign clr_count = wr_ctrl && bus.avs_writedata[1];
    assign pass      = (cap_id_q == EXPECTED_ID) && (!CHECK_TS || (cap_ts_q == EXPECTED_TS));

    // Reads are always valid, so the strobe and upper command bits carry no meaning here.
    assign unused_bits = ^{bus.avs_read, bus.avs_writedata[31:2]};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= StSettle;
            cnt_q    <= '0;
            addr_q   <= 1'b0;
            cap_id_q <= '0;
            cap_ts_q <= '0;
            ok_q     <= 1'b0;
            fail_q   <= 1'b0;
            done_q   <= 1'b0;
            mism_q   <= '0;
            oled_q   <= 1'b0;
            idf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            cap_id_q <= cap_id_d;
            cap_ts_q <= cap_ts_d;
            ok_q     <= ok_d;
            fail_q   <= fail_d;
            done_q   <= done_d;
            mism_q   <= mism_d;
            oled_q   <= oled_d;
            idf_q    <= idf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        cap_id_d = cap_id_q;
        cap_ts_d = cap_ts_q;
        ok_d     = ok_q;
        fail_d   = fail_q;
        done_d   = done_q;
        mism_d   = mism_q;

        unique case (state_q)
            StSettle: begin
                if (SkipSettle) begin
                    // No settle time: address is already 0, so the first edge captures the ID.
                    cap_id_d = sysid_readdata;
                    addr_d   = 1'b1;
                    state_d  = StRdTs;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == SettleLast) begin
                        state_d = StRdId;
                    end
                end
            end
            StRdId: begin
                cap_id_d = sysid_readdata;
                addr_d   = 1'b1;
                state_d  = StRdTs;
            end
            StRdTs: begin
                cap_ts_d = sysid_readdata;
                addr_d   = 1'b0;
                state_d  = StCmp;
            end
            StCmp: begin
                ok_d   = pass;
                fail_d = !pass;
                done_d = 1'b1;
                if (!pass && (mism_q != 8'hFF)) begin
                    mism_d = mism_q + 8'd1;
                end
                state_d = StDone;
            end
            StDone: begin
                if (recheck) begin
                    ok_d    = 1'b0;
                    fail_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = StRdId;
                end
            end
            default: begin
                state_d = StSettle;
            end
        endcase

        // Clear beats a same-edge increment.
        if (clr_count) begin
            mism_d = '0;
        end

        oled_d = done_d & ok_d;
        idf_d  = done_d & fail_d;
    end

    always_comb begin
        bus.avs_readdata = '0;
        unique case (bus.avs_address)
            2'd0: bus.avs_readdata = {16'd0, mism_q, 4'd0, (state_q != StDone), fail_q, ok_q,
                                      done_q};
            2'd1: bus.avs_readdata = cap_id_q;
            2'd2: bus.avs_readdata = cap_ts_q;
            2'd3: bus.avs_readdata = EXPECTED_ID;
            default: bus.avs_readdata = '0;
        endcase
    end

    assign sysid_address = addr_q;
    assign oled_enable   = oled_q;
    assign id_fail       = idf_q;

endmodule
